ts_sync_aligner: RTL and testbench

Byte-wide MPEG-TS packet aligner that sits directly upstream of `ts_proxy`, between the demod byte deserializer (or TSGEN) and the EP3 USB packer. It hunts for the 0x47 sync byte, confirms 188-byte periodicity before declaring lock, and forwards only whole, aligned packets with start, end and error markers. It also maintains packet and sync-loss statistics.

---
 rtl/ts_pkg.sv | 23 ++
 rtl/ts_sync_aligner.sv | 192 +++++++++++++++++++
 tb/tb_ts_sync_aligner.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// ---------------------------------------------------------------------------
// ts_pkg
// Shared MPEG-TS constants and the aligner state encoding. The aligner,
// ts_proxy and the TS generator all import these, so the packet length and
// the sync byte are defined in exactly one place.
//
// Contents:
//   TS_PKT_LEN   - transport stream packet length in bytes (188)
//   TS_SYNC_BYTE - packet sync byte value (0x47)
//   ts_state_e   - aligner FSM states (HUNT=0, VERIFY=1, LOCK=2)
// ---------------------------------------------------------------------------
package ts_pkg;

    localparam int unsigned TS_PKT_LEN   = 188;
    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        TS_HUNT   = 2'd0,
        TS_VERIFY = 2'd1,
        TS_LOCK   = 2'd2
    } ts_state_e;

endpackage : ts_pkg

// File: rtl/ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// ts_sync_aligner
// Byte-wide MPEG-TS packet aligner. Hunts for the 0x47 sync byte, confirms
// LOCK_CNT correctly spaced syncs before locking, and then forwards only
// whole packets, marking byte 0 (out_start), byte PKT_LEN-1 (out_end) and
// tolerated bad sync bytes (out_err). Lock is dropped after UNLOCK_CNT
// consecutive missing syncs. All outputs are registered, one cycle latency.
//
// Ports:
//   clk            - single clock
//   reset          - synchronous, active-high
//   in_data[7:0]   - byte from the upstream deserializer
//   in_valid       - in_data is valid; all state advances only when high
//   in_start       - upstream start-of-packet hint (used when USE_START=1)
//   out_data[7:0]  - forwarded byte
//   out_valid      - out_data is valid
//   out_start      - packet byte index 0
//   out_end        - packet byte index PKT_LEN-1
//   out_err        - with out_start: byte 0 was not 0x47 while locked
//   locked         - aligner is in LOCK
//   stat_pkt_cnt   - packets started on the output (wraps)
//   stat_sync_loss - LOCK->HUNT transitions (saturates at 0xFFFF)
// ---------------------------------------------------------------------------
module ts_sync_aligner
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN    = TS_PKT_LEN,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter bit          USE_START  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_start,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_start,
    output logic        out_end,
    output logic        out_err,
    output logic        locked,
    output logic [31:0] stat_pkt_cnt,
    output logic [15:0] stat_sync_loss
);

    localparam int unsigned      IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
    localparam logic [3:0]       GOOD_TGT = 4'(LOCK_CNT);
    localparam logic [3:0]       MISS_TGT = 4'(UNLOCK_CNT);

    // Sequential state
    ts_state_e        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_good;
    logic [3:0]       r_miss;

    // Registered outputs
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_start;
    logic             r_out_end;
    logic             r_out_err;
    logic             r_locked;
    logic [31:0]      r_pkt_cnt;
    logic [15:0]      r_sync_loss;

    // Per-byte decode
    logic             w_is_sync;
    logic             w_hunt_hit;
    logic             w_at_zero;
    logic             w_at_last;
    logic [IDX_W-1:0] w_idx_next;
    logic [3:0]       w_good_inc;
    logic [3:0]       w_miss_inc;

    assign w_is_sync  = (in_data == TS_SYNC_BYTE);
    // With USE_START the upstream hint must agree before a sync opens VERIFY.
    assign w_hunt_hit = w_is_sync && (!USE_START || in_start);
    assign w_at_zero  = (r_idx == '0);
    assign w_at_last  = (r_idx == IDX_LAST);
    assign w_idx_next = w_at_last ? '0 : r_idx + IDX_W'(1);
    assign w_good_inc = r_good + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;

    // NOTE: every register in this block uses non-blocking assignment so all
    // state and outputs update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= TS_HUNT;
            r_idx       <= '0;
            r_good      <= '0;
            r_miss      <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_end   <= 1'b0;
            r_out_err   <= 1'b0;
            r_locked    <= 1'b0;
            r_pkt_cnt   <= '0;
            r_sync_loss <= '0;
        end else begin
            // Markers are single-byte pulses: they clear on every cycle that
            // does not forward a byte, which also gates them on out_valid.
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_out_end   <= 1'b0;
            r_out_err   <= 1'b0;

            if (in_valid) begin
                case (r_state)
                    TS_HUNT: begin
                        if (w_hunt_hit) begin
                            r_idx   <= IDX_W'(1);
                            r_good  <= 4'd1;
                            r_state <= TS_VERIFY;
                        end
                    end

                    TS_VERIFY: begin
                        r_idx <= w_idx_next;
                        if (w_at_zero) begin
                            if (w_is_sync) begin
                                r_good <= w_good_inc;
                                if (w_good_inc == GOOD_TGT) begin
                                    // The confirming sync is itself the first
                                    // forwarded packet start.
                                    r_state     <= TS_LOCK;
                                    r_locked    <= 1'b1;
                                    r_miss      <= '0;
                                    r_out_valid <= 1'b1;
                                    r_out_start <= 1'b1;
                                    r_out_data  <= in_data;
                                    r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                                end
                            end else begin
                                r_state <= TS_HUNT;
                            end
                        end
                    end

                    TS_LOCK: begin
                        r_idx <= w_idx_next;
                        if (w_at_zero) begin
                            if (w_is_sync) begin
                                r_miss      <= '0;
                                r_out_valid <= 1'b1;
                                r_out_start <= 1'b1;
                                r_out_data  <= in_data;
                                r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                            end else if (w_miss_inc == MISS_TGT) begin
                                // Drop lock on a packet boundary: the previous
                                // byte carried out_end, this one is discarded.
                                r_miss   <= w_miss_inc;
                                r_state  <= TS_HUNT;
                                r_locked <= 1'b0;
                                if (r_sync_loss != 16'hFFFF) begin
                                    r_sync_loss <= r_sync_loss + 16'd1;
                                end
                            end else begin
                                r_miss      <= w_miss_inc;
                                r_out_valid <= 1'b1;
                                r_out_start <= 1'b1;
                                r_out_err   <= 1'b1;
                                r_out_data  <= in_data;
                                r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                            end
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_end   <= w_at_last;
                            r_out_data  <= in_data;
                        end
                    end

                    default: begin
                        r_state <= TS_HUNT;
                    end
                endcase
            end
        end
    end

    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign out_start      = r_out_start;
    assign out_end        = r_out_end;
    assign out_err        = r_out_err;
    assign locked         = r_locked;
    assign stat_pkt_cnt   = r_pkt_cnt;
    assign stat_sync_loss = r_sync_loss;

endmodule : ts_sync_aligner

// File: tb/tb_ts_sync_aligner.sv
// ---------------------------------------------------------------------------
// tb_ts_sync_aligner
// Self-checking bench for ts_sync_aligner. Each scenario builds a byte
// stream, a packet-level reference model predicts which bytes come out and
// with which markers, and every cycle's outputs are compared against it.
// Directed scenarios add hand-derived checks on lock/unlock positions and
// counters.
// ---------------------------------------------------------------------------
module tb_ts_sync_aligner;
    import ts_pkg::*;

    localparam int L   = TS_PKT_LEN;
    localparam int LCK = 3;
    localparam int ULK = 2;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_start = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_start;
    logic        out_end;
    logic        out_err;
    logic        locked;
    logic [31:0] stat_pkt_cnt;
    logic [15:0] stat_sync_loss;

    ts_sync_aligner #(
        .PKT_LEN    (L),
        .LOCK_CNT   (LCK),
        .UNLOCK_CNT (ULK),
        .USE_START  (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_start       (in_start),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_start      (out_start),
        .out_end        (out_end),
        .out_err        (out_err),
        .locked         (locked),
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_sync_loss (stat_sync_loss)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       fwd;
        logic       st;
        logic       en;
        logic       er;
        logic [7:0] d;
    } exp_t;

    logic [7:0] stim[$];
    exp_t       exp_q[$];
    int         m_pkt;
    int         m_loss;

    // Observed per-stream statistics (indices are valid-byte positions).
    int o_start, o_end, o_err;
    int o_first_rise, o_last_rise, o_first_fall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic fwd, input logic st, input logic en,
                                input logic er, input logic [7:0] d);
        exp_t e;
        e.fwd = fwd; e.st = st; e.en = en; e.er = er; e.d = d;
        return e;
    endfunction

    // Packet-level model: find a sync, test the bytes exactly L apart, then
    // walk whole packets from the lock point until lock is lost.
    task automatic build_model();
        int  n;
        int  pos;
        int  p;
        int  q;
        int  s;
        int  miss;
        bit  found;
        bit  ok;
        bit  done;
        n = stim.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, 8'h00));
        m_pkt  = 0;
        m_loss = 0;
        pos    = 0;
        p      = 0;
        done   = 0;
        while (!done && pos < n) begin
            found = 0;
            for (int i = pos; i < n; i++) begin
                if (stim[i] == TS_SYNC_BYTE) begin
                    p = i; found = 1; break;
                end
            end
            if (!found) break;
            ok = 1;
            for (int k = 1; k < LCK; k++) begin
                q = p + k * L;
                if (q >= n) begin done = 1; ok = 0; break; end
                if (stim[q] != TS_SYNC_BYTE) begin pos = q + 1; ok = 0; break; end
            end
            if (!ok) continue;
            s    = p + (LCK - 1) * L;
            miss = 0;
            forever begin
                if (s >= n) begin done = 1; break; end
                if (stim[s] == TS_SYNC_BYTE) begin
                    miss = 0;
                end else begin
                    miss++;
                    if (miss == ULK) begin m_loss++; pos = s + 1; break; end
                end
                exp_q[s] = mk(1, 1, 0, miss != 0, stim[s]);
                m_pkt++;
                for (int j = 1; j < L && s + j < n; j++)
                    exp_q[s + j] = mk(1, 0, j == L - 1, 0, stim[s + j]);
                s += L;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic st);
        in_valid = v;
        in_data  = d;
        in_start = st;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] obs_vec();
        return {out_valid, out_start, out_end, out_err, locked,
                out_valid ? out_data : 8'h00};
    endfunction

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = TS_SYNC_BYTE;
        in_start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " reset outputs"},
              {out_valid, out_start, out_end, out_err, locked, out_data}, 64'd0);
        check({tag, " reset counters"}, {stat_pkt_cnt, stat_sync_loss}, 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    // gap_mode: 0 = continuous, 1 = valid toggles 1/0, 2 = random idle gaps
    task automatic run_stream(input string tag, input int gap_mode);
        logic exp_locked;
        logic prev_locked;
        int   gaps;
        exp_t e;
        build_model();
        exp_locked   = locked;
        prev_locked  = locked;
        o_start      = 0;
        o_end        = 0;
        o_err        = 0;
        o_first_rise = -1;
        o_last_rise  = -1;
        o_first_fall = -1;
        for (int i = 0; i < stim.size(); i++) begin
            gaps = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
                   (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, 8'($urandom), 1'($urandom));
                check({tag, " idle"}, obs_vec(), {4'b0000, exp_locked, 8'h00});
            end
            drive(1'b1, stim[i], 1'($urandom));
            e = exp_q[i];
            exp_locked = e.fwd;
            check($sformatf("%s byte %0d", tag, i), obs_vec(),
                  {e.fwd, e.st, e.en, e.er, exp_locked, e.fwd ? e.d : 8'h00});
            if (out_start) o_start++;
            if (out_end)   o_end++;
            if (out_err)   o_err++;
            if (locked && !prev_locked) begin
                if (o_first_rise < 0) o_first_rise = i;
                o_last_rise = i;
            end
            if (!locked && prev_locked && o_first_fall < 0) o_first_fall = i;
            prev_locked = locked;
        end
        check({tag, " stat_pkt_cnt"}, stat_pkt_cnt, m_pkt);
        check({tag, " stat_sync_loss"}, stat_sync_loss, m_loss);
    endtask

    task automatic push_clean(input int n_pkts, input int corrupt_mask);
        for (int p = 0; p < n_pkts; p++) begin
            stim.push_back(corrupt_mask[p] ? 8'h46 : TS_SYNC_BYTE);
            for (int j = 1; j < L; j++) stim.push_back(8'hAA);
        end
    endtask

    function automatic logic [7:0] non_sync();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        if (b >= TS_SYNC_BYTE) b = b + 8'd1;
        return b;
    endfunction

    initial begin
        // Clean stream: lock on the third sync, packets 3..5 forwarded.
        do_reset("clean");
        stim.delete();
        push_clean(5, 0);
        run_stream("clean", 0);
        check("clean first lock idx", o_first_rise, 376);
        check("clean starts", o_start, 3);
        check("clean ends", o_end, 3);
        check("clean pkt_cnt", stat_pkt_cnt, 3);

        // Junk prefix with a stray sync at byte 20 that swallows the real
        // sync at 50; lock comes on the syncs at 238/426/614.
        do_reset("junk");
        stim.delete();
        for (int i = 0; i < 50; i++) stim.push_back(i == 20 ? TS_SYNC_BYTE : non_sync());
        push_clean(5, 0);
        run_stream("junk", 0);
        check("junk first lock idx", o_first_rise, 614);
        check("junk starts", o_start, 2);

        // Isolated bad syncs on packets 4 and 6: both flagged, lock held,
        // which also shows miss clearing on packet 5.
        do_reset("single");
        stim.delete();
        push_clean(7, 32'b0010_1000);
        run_stream("single", 0);
        check("single err count", o_err, 2);
        check("single no unlock", o_first_fall, -1);
        check("single still locked", locked, 1'b1);
        check("single pkt_cnt", stat_pkt_cnt, 5);

        // Bad syncs on packets 4 and 5: drop at byte 752, relock at 1316.
        do_reset("double");
        stim.delete();
        push_clean(10, 32'b0001_1000);
        run_stream("double", 0);
        check("double unlock idx", o_first_fall, 752);
        check("double relock idx", o_last_rise, 1316);
        check("double sync_loss", stat_sync_loss, 1);
        check("double start/end balance", {o_start, o_end}, {32'd5, 32'd5});

        // Gapped valid: same output bytes, idle cycles show nothing.
        do_reset("gapped");
        stim.delete();
        push_clean(5, 0);
        run_stream("gapped", 1);
        check("gapped first lock idx", o_first_rise, 376);
        check("gapped starts", o_start, 3);

        // Reset at byte 100 of packet 4 while locked, then relock.
        do_reset("midreset");
        stim.delete();
        push_clean(3, 0);
        stim.push_back(TS_SYNC_BYTE);
        for (int j = 1; j <= 100; j++) stim.push_back(8'hAA);
        run_stream("midreset A", 0);
        check("midreset locked before", locked, 1'b1);
        check("midreset A starts/ends", {o_start, o_end}, {32'd2, 32'd1});
        do_reset("midreset");
        stim.delete();
        push_clean(5, 0);
        run_stream("midreset B", 0);
        check("midreset relock idx", o_first_rise, 376);

        // Random streams: random junk, payloads and bad syncs, random gaps.
        for (int it = 0; it < 2; it++) begin
            do_reset("random");
            stim.delete();
            for (int i = 0; i < int'($urandom_range(0, 200)); i++) stim.push_back(8'($urandom));
            for (int p = 0; p < 12; p++) begin
                stim.push_back(($urandom_range(0, 3) == 0) ? non_sync() : TS_SYNC_BYTE);
                for (int j = 1; j < L; j++) stim.push_back(8'($urandom));
            end
            run_stream($sformatf("random%0d", it), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ts_sync_aligner
